div_unit: RTL and testbench

Multi-cycle 32-bit integer divider and its sequencing state machine for the execute stage. Accepts a start request from EX, computes quotient and remainder over 32 iterations of restoring division, and holds the 64-bit result until EX releases it. EX raises its divide stall request while a divide is in flight and ready_o is low. Annul support lets the pipeline cancel an in-flight divide.

---
 rtl/div_unit.sv | 189 ++++++++++++++++++
 tb/tb_div_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- multi-cycle 32-bit restoring divider for the execute stage.
//
// Accepts a divide request from EX, runs 32 restoring iterations and holds
// {remainder, quotient} until EX drops start_i. A divide by zero finishes in
// one cycle with a zero result. annul_i cancels a divide that is still
// computing; it has no effect once the result is presented.
//
// Configuration macro: DIV_SIGNED_EN
//   defined   : signed_i selects DIV (signed) or DIVU (unsigned).
//   undefined : signed_i is ignored and every divide is unsigned. Latency is
//               the same in both builds.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   signed_i   in   1   1 = signed divide, 0 = unsigned
//   opdata1_i  in  32   dividend (sampled only on the accepting edge)
//   opdata2_i  in  32   divisor  (sampled only on the accepting edge)
//   start_i    in   1   divide request, held high until the result is consumed
//   annul_i    in   1   cancel the divide in flight
//   result_o   out 64   {remainder[63:32], quotient[31:0]}
//   ready_o    out  1   result_o valid
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;      // {partial_rem[64:32], quot[31:0]}
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_c, rem_c;

`ifdef DIV_SIGNED_EN
    logic dvd_sign_q, dvd_sign_d;
    logic dvs_sign_q, dvs_sign_d;

    // Two's-complement negation, modulo 2^32 (so -0x80000000 stays 0x80000000).
    function automatic logic [31:0] neg32(input logic signed [31:0] x);
        return -x;
    endfunction
`else
    // signed_i has no function in the unsigned-only build.
    logic unused_signed;
    assign unused_signed = signed_i;
`endif

    // The partial remainder never exceeds the divisor, so the top bit of the
    // working register is always zero after a step and is never read back.
    logic unused_work_top;
    assign unused_work_top = work_q[64];

    // One restoring step: shift, then trial-subtract the divisor.
    assign shifted = {work_q[63:0], 1'b0};
    assign diff    = shifted[64:32] - {1'b0, divisor_q};

    // Sign correction applied when the iterations are complete.
    always_comb begin
        quot_c = work_q[31:0];
        rem_c  = work_q[63:32];
`ifdef DIV_SIGNED_EN
        if (dvd_sign_q ^ dvs_sign_q) begin
            quot_c = neg32(work_q[31:0]);
        end
        if (dvd_sign_q) begin
            rem_c = neg32(work_q[63:32]);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        dvd_sign_d = dvd_sign_q;
        dvs_sign_d = dvs_sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
`ifdef DIV_SIGNED_EN
                    dvd_sign_d = signed_i & opdata1_i[31];
                    dvs_sign_d = signed_i & opdata2_i[31];
                    work_d     = {33'd0, (signed_i & opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i};
                    divisor_d  = (signed_i & opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
`else
                    work_d     = {33'd0, opdata1_i};
                    divisor_d  = opdata2_i;
`endif
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = 6'd0;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    // A clear MSB means the trial subtraction did not borrow.
                    if (!diff[32]) begin
                        work_d = {diff, shifted[31:1], 1'b1};
                    end else begin
                        work_d = shifted;
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_c, quot_c};
                    ready_d  = 1'b1;
                    state_d  = END;
                    cnt_d    = 6'd0;
                end
            end
            END: begin
                // annul_i is deliberately ignored: the result is already committed.
                if (!start_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath registers: only meaningful once loaded from IDLE
    always_ff @(posedge clk) begin
        work_q    <= work_d;
        divisor_q <= divisor_d;
`ifdef DIV_SIGNED_EN
        dvd_sign_q <= dvd_sign_d;
        dvs_sign_q <= dvs_sign_d;
`endif
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. Expected results are queued when a divide
// is issued and popped when ready_o rises. Works in both builds
// (DIV_SIGNED_EN defined or not).
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    // Reference divide using the simulator's own / and % operators.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic na, nb, s;
`ifdef DIV_SIGNED_EN
        s = sgn;
`else
        s = 1'b0;
`endif
        if (b == 32'd0) return 64'd0;
        na = s & a[31];
        nb = s & b[31];
        ua = na ? 32'd0 - a : a;
        ub = nb ? 32'd0 - b : b;
        q = ua / ub;
        r = ua % ub;
        if (na ^ nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide, wait for ready_o, then check latency, value, hold and release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv);
        int n;
        logic [63:0] e;
        exp_q.push_back(expv);
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        tick();                      // edge k: request accepted
        opdata1_i = $urandom;        // operands must be ignored from here on
        opdata2_i = $urandom;
        signed_i  = ~sgn;
        n = 0;
        while (n < 40 && !ready_o) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
        e = exp_q.pop_front();
        check({tag, "_result"}, result_o, e);
        tick();
        check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_res"}, result_o, e);
        start_i = 1'b0;
        tick();
        check({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_rel_res"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic rs;

        rst = 1'b1; signed_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        start_i = 1'b0; annul_i = 1'b0;
        tick();
        tick();
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        rst = 1'b0;
        tick();

        do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E});
`ifdef DIV_SIGNED_EN
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
`else
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'h00000001, 32'h7FFFFFFC});
        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000});
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000007, 32'h00000000});
`endif
        do_div("div0", 1'b0, 32'd5, 32'd0, 64'd0);
        do_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF});
        do_div("u_small", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0});

        // Annul at iteration 10: no result may ever appear.
        signed_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready_o) seen++;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen++;
        end
        annul_i = 1'b0;
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_res", result_o, 64'd0);
        do_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'd3, {32'h0, 32'h55555555});

        // Start together with annul is refused.
        opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen++;
        end
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul_refused", 64'(seen), 64'd0);
        tick();

        // Reset mid-divide at iteration 20.
        signed_i = 1'b1; opdata1_i = 32'h12345678; opdata2_i = 32'd17; start_i = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        check("rst_mid_rdy", 64'(ready_o), 64'd0);
        check("rst_mid_res", result_o, 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen++;
        end
        check("rst_mid_idle", 64'(seen), 64'd0);
        do_div("after_rst", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30});

        // Random vectors against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (i == 5) rb = 32'd0;
            rs = 1'(i % 3 == 0);
            do_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
